// File: rtl/dp_lt_pkg.sv
// Shared DisplayPort link-training types and codes: FSM states, TPS/lane/rate
// codes, the applied-config record and the rate/lane legality check.
package dp_lt_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_APPLY  = 2'd1,
      ST_SETTLE = 2'd2,
      ST_DONE   = 2'd3
   } seq_state_e;

   localparam logic [1:0] TPS_NONE = 2'b00;
   localparam logic [1:0] TPS_1    = 2'b01;
   localparam logic [1:0] TPS_2    = 2'b10;
   localparam logic [1:0] TPS_3    = 2'b11;

   localparam logic [1:0] LC_1     = 2'b00;
   localparam logic [1:0] LC_2     = 2'b01;
   localparam logic [1:0] LC_4     = 2'b11;
   localparam logic [1:0] LC_BAD   = 2'b10;

   localparam logic [7:0] BW_RBR   = 8'h06;
   localparam logic [7:0] BW_HBR   = 8'h0A;
   localparam logic [7:0] BW_HBR2  = 8'h14;
   localparam logic [7:0] BW_HBR3  = 8'h1E;

   typedef struct packed {
      logic [1:0] tps;
      logic [1:0] lc;
      logic [7:0] bw;
   } phy_cfg_t;

   function automatic logic cfg_legal(input logic [1:0] lc, input logic [7:0] bw);
      logic bw_ok;
      bw_ok = (bw == BW_RBR) || (bw == BW_HBR) || (bw == BW_HBR2) || (bw == BW_HBR3);
      return (lc != LC_BAD) && bw_ok;
   endfunction

endpackage

// File: rtl/phy_cfg_seq.sv
// PHY configuration sequencer: applies training-pattern / lane / rate requests
// and times the PHY settle window. Optional ovr_cnt port under PHY_CFG_SEQ_STATUS_EN.
module phy_cfg_seq
   import dp_lt_pkg::*;
#(
   parameter int SETTLE_LONG  = 100,
   parameter int SETTLE_SHORT = 4
)(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] phy_instruct,
   input  logic       phy_instruct_vld,
   input  logic [1:0] phy_adj_lc,
   input  logic [7:0] phy_adj_bw,
   output logic [1:0] phy_tps_o,
   output logic [1:0] phy_lc_o,
   output logic [7:0] phy_bw_o,
   output logic       phy_cfg_stb,
   output logic       phy_settled,
   output logic       seq_busy,
   output logic       cfg_err
`ifdef PHY_CFG_SEQ_STATUS_EN
   ,
   output logic [7:0] ovr_cnt
`endif
);

   localparam int SETTLE_MAX = (SETTLE_LONG > SETTLE_SHORT) ? SETTLE_LONG : SETTLE_SHORT;
   localparam int CNT_W      = (SETTLE_MAX < 1) ? 1 : $clog2(SETTLE_MAX + 1);

   seq_state_e       state_q, state_d;
   phy_cfg_t         cur_q, cur_d;
   phy_cfg_t         pend_q, pend_d;
   logic             pend_vld_q, pend_vld_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   phy_cfg_t         in_req, start_req;
   logic             in_ok, in_bad, start, rate_change;

   assign in_req = '{tps: phy_instruct, lc: phy_adj_lc, bw: phy_adj_bw};
   assign in_ok  = phy_instruct_vld &&  cfg_legal(phy_adj_lc, phy_adj_bw);
   assign in_bad = phy_instruct_vld && !cfg_legal(phy_adj_lc, phy_adj_bw);

   // Outputs and settle count are committed on the edge into APPLY, so the
   // long/short decision compares against the values being replaced.
   assign rate_change = (start_req.lc != cur_q.lc) || (start_req.bw != cur_q.bw);

   always_comb begin
      state_d    = state_q;
      cur_d      = cur_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      cnt_d      = cnt_q;
      err_d      = err_q | in_bad;
      start      = 1'b0;
      start_req  = in_req;
      case (state_q)
         ST_IDLE: begin
            if (in_ok) start = 1'b1;
         end
         ST_APPLY, ST_SETTLE: begin
            if (in_ok) begin
               pend_d     = in_req;
               pend_vld_d = 1'b1;
            end
            if (state_q == ST_APPLY) begin
               state_d = ST_SETTLE;
            end else begin
               if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q <= CNT_W'(1)) state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            // A request arriving right now is newer than anything buffered.
            pend_vld_d = 1'b0;
            if (in_ok) begin
               start = 1'b1;
            end else if (pend_vld_q) begin
               start     = 1'b1;
               start_req = pend_q;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (start) begin
         state_d = ST_APPLY;
         cur_d   = start_req;
         cnt_d   = rate_change ? CNT_W'(SETTLE_LONG) : CNT_W'(SETTLE_SHORT);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cur_q      <= '{tps: TPS_NONE, lc: LC_1, bw: BW_RBR};
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cur_q      <= cur_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
      end
   end

   assign phy_tps_o   = cur_q.tps;
   assign phy_lc_o    = cur_q.lc;
   assign phy_bw_o    = cur_q.bw;
   assign phy_cfg_stb = (state_q == ST_APPLY);
   assign phy_settled = (state_q == ST_DONE);
   assign seq_busy    = (state_q != ST_IDLE);
   assign cfg_err     = err_q;

`ifdef PHY_CFG_SEQ_STATUS_EN
   logic [7:0] ovr_q;
   always_ff @(posedge clk) begin
      if (rst)                                   ovr_q <= 8'h00;
      else if (in_ok && pend_vld_q && ovr_q != 8'hFF) ovr_q <= ovr_q + 8'h01;
   end
   assign ovr_cnt = ovr_q;
`endif

endmodule

// File: tb/tb_phy_cfg_seq.sv
// Bench for phy_cfg_seq: timeline model checked every cycle plus literal
// expectations for the key latencies and boundary cases.
module tb_phy_cfg_seq;

   localparam int SL = 100;
   localparam int SS = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] phy_instruct = 2'b00;
   logic       phy_instruct_vld = 1'b0;
   logic [1:0] phy_adj_lc = 2'b00;
   logic [7:0] phy_adj_bw = 8'h06;
   logic [1:0] phy_tps_o, phy_lc_o;
   logic [7:0] phy_bw_o;
   logic       phy_cfg_stb, phy_settled, seq_busy, cfg_err;
`ifdef PHY_CFG_SEQ_STATUS_EN
   logic [7:0] ovr_cnt;
`endif

   phy_cfg_seq #(.SETTLE_LONG(SL), .SETTLE_SHORT(SS)) dut (
      .clk(clk), .rst(rst),
      .phy_instruct(phy_instruct), .phy_instruct_vld(phy_instruct_vld),
      .phy_adj_lc(phy_adj_lc), .phy_adj_bw(phy_adj_bw),
      .phy_tps_o(phy_tps_o), .phy_lc_o(phy_lc_o), .phy_bw_o(phy_bw_o),
      .phy_cfg_stb(phy_cfg_stb), .phy_settled(phy_settled),
      .seq_busy(seq_busy), .cfg_err(cfg_err)
`ifdef PHY_CFG_SEQ_STATUS_EN
      , .ovr_cnt(ovr_cnt)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   int n_vec = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   // Model: each accepted request is a window [apply, done] on the cycle axis.
   int         m_apply = -1, m_done = -1, m_ovr = 0;
   logic [1:0] m_tps = 2'b00, m_lc = 2'b00, p_tps = 2'b00, p_lc = 2'b00;
   logic [7:0] m_bw = 8'h06, p_bw = 8'h06;
   bit         m_pv = 1'b0, m_err = 1'b0;

   int stb_cyc = -1, set_cyc = -1, stb_n = 0, set_n = 0;

   function automatic bit legal(input logic [1:0] l, input logic [7:0] b);
      return (l != 2'b10) && (b == 8'h06 || b == 8'h0A || b == 8'h14 || b == 8'h1E);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   always @(posedge clk) begin : model
      int n, s;
      bit idle, start, ok;
      logic [1:0] st, sl;
      logic [7:0] sb;
      n = cyc;
      if (rst) begin
         m_apply = -1; m_done = -1; m_ovr = 0;
         m_tps = 2'b00; m_lc = 2'b00; m_bw = 8'h06;
         m_pv = 1'b0; m_err = 1'b0;
      end else begin
         ok    = phy_instruct_vld && legal(phy_adj_lc, phy_adj_bw);
         idle  = !(n >= m_apply && n <= m_done);
         start = 1'b0;
         st = phy_instruct; sl = phy_adj_lc; sb = phy_adj_bw;
         if (phy_instruct_vld && !ok) m_err = 1'b1;
         if (idle) begin
            if (ok) start = 1'b1;
         end else if (n == m_done) begin
            if (ok) begin
               start = 1'b1;
               if (m_pv && m_ovr < 255) m_ovr++;
            end else if (m_pv) begin
               start = 1'b1; st = p_tps; sl = p_lc; sb = p_bw;
            end
            m_pv = 1'b0;
         end else if (ok) begin
            if (m_pv && m_ovr < 255) m_ovr++;
            m_pv = 1'b1; p_tps = st; p_lc = sl; p_bw = sb;
         end
         if (start) begin
            s = (sl != m_lc || sb != m_bw) ? SL : SS;
            if (s < 1) s = 1;
            m_tps = st; m_lc = sl; m_bw = sb;
            m_apply = n + 1;
            m_done  = n + 2 + s;
         end
      end
      cyc = cyc + 1;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("stb",     phy_cfg_stb, 32'(cyc == m_apply));
         chk("settled", phy_settled, 32'(cyc == m_done));
         chk("busy",    seq_busy,    32'(cyc >= m_apply && cyc <= m_done));
         chk("tps",     phy_tps_o,   m_tps);
         chk("lc",      phy_lc_o,    m_lc);
         chk("bw",      phy_bw_o,    m_bw);
         chk("err",     cfg_err,     m_err);
`ifdef PHY_CFG_SEQ_STATUS_EN
         chk("ovr",     ovr_cnt,     m_ovr);
`endif
         if (phy_cfg_stb) begin stb_cyc = cyc; stb_n++; end
         if (phy_settled) begin set_cyc = cyc; set_n++; end
      end
   end

   task automatic send(input logic [1:0] t, input logic [1:0] l, input logic [7:0] b,
                       output int n);
      n = cyc;
      phy_instruct = t; phy_adj_lc = l; phy_adj_bw = b; phy_instruct_vld = 1'b1;
      @(posedge clk); #1;
      phy_instruct_vld = 1'b0;
   endtask

   task automatic wait_to(input int t);
      while (cyc < t) begin @(posedge clk); #1; end
   endtask

   initial begin
      int n, m, k;
      @(posedge clk); #1;
      chk_en = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b0;
      chk("rst_tps",  phy_tps_o, 2'b00);
      chk("rst_lc",   phy_lc_o,  2'b00);
      chk("rst_bw",   phy_bw_o,  8'h06);
      chk("rst_busy", seq_busy,  1'b0);
      chk("rst_err",  cfg_err,   1'b0);

      // Long settle: lane count and rate both change.
      send(2'b01, 2'b11, 8'h0A, n);
      wait_to(n + 110);
      chk("long_stb_at", stb_cyc, n + 1);
      chk("long_set_at", set_cyc, n + 102);
      chk("long_tps", phy_tps_o, 2'b01);
      chk("long_lc",  phy_lc_o,  2'b11);
      chk("long_bw",  phy_bw_o,  8'h0A);

      // Pattern-only change: short settle.
      send(2'b10, 2'b11, 8'h0A, n);
      wait_to(n + 10);
      chk("short_set_at", set_cyc, n + 6);
      chk("short_tps", phy_tps_o, 2'b10);

      // Request in the DONE cycle goes straight to APPLY.
      send(2'b01, 2'b11, 8'h0A, n);
      wait_to(n + 6);
      send(2'b11, 2'b11, 8'h0A, m);
      wait_to(n + 20);
      chk("done_req_stb_at", stb_cyc, n + 7);
      chk("done_req_set_at", set_cyc, n + 12);
      chk("done_req_tps", phy_tps_o, 2'b11);

      // Two requests during SETTLE: only the newer one is served.
      k = stb_n;
      send(2'b01, 2'b00, 8'h06, n);
      wait_to(n + 5);
      send(2'b10, 2'b00, 8'h06, m);
      wait_to(n + 10);
      send(2'b11, 2'b00, 8'h06, m);
      wait_to(n + 115);
      chk("pend_stb_at", stb_cyc, n + 103);
      chk("pend_set_at", set_cyc, n + 108);
      chk("pend_stb_n",  stb_n - k, 2);
      chk("pend_tps",    phy_tps_o, 2'b11);
`ifdef PHY_CFG_SEQ_STATUS_EN
      chk("pend_ovr",    ovr_cnt, 8'd1);
`endif

      // Illegal lane count, then illegal rate: nothing applied, error sticks.
      k = stb_n;
      send(2'b01, 2'b10, 8'h0A, n);
      wait_to(n + 3);
      chk("bad_lc_err",  cfg_err,   1'b1);
      chk("bad_lc_stb",  stb_n - k, 0);
      chk("bad_lc_busy", seq_busy,  1'b0);
      chk("bad_lc_lc",   phy_lc_o,  2'b00);
      send(2'b01, 2'b11, 8'h07, n);
      wait_to(n + 3);
      chk("bad_bw_stb",  stb_n - k, 0);
      chk("bad_bw_bw",   phy_bw_o,  8'h06);

      // Legal request with an illegal one arriving during SETTLE.
      k = stb_n;
      send(2'b10, 2'b01, 8'h1E, n);
      wait_to(n + 20);
      send(2'b11, 2'b10, 8'h14, m);
      wait_to(n + 110);
      chk("mix_stb_n", stb_n - k, 1);
      chk("mix_lc",    phy_lc_o,  2'b01);
      chk("mix_bw",    phy_bw_o,  8'h1E);
      chk("mix_err",   cfg_err,   1'b1);

      // Reset mid-SETTLE aborts without a settled pulse.
      k = set_n;
      send(2'b01, 2'b11, 8'h14, n);
      wait_to(n + 50);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_busy", seq_busy,  1'b0);
      chk("abort_tps",  phy_tps_o, 2'b00);
      chk("abort_lc",   phy_lc_o,  2'b00);
      chk("abort_bw",   phy_bw_o,  8'h06);
      chk("abort_err",  cfg_err,   1'b0);
      wait_to(cyc + 110);
      chk("abort_no_settle", set_n - k, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/phy_cfg_seq.md
PHY_CFG_SEQ -- requirements
Module: phy_cfg_seq

Interface
REQ-001 SHALL have parameter SETTLE_LONG, 100: settle cycles after a link-rate or lane-count change.
REQ-002 SHALL have parameter SETTLE_SHORT, 4: settle cycles after a training-pattern-only change.
REQ-003 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port phy_instruct  in  2  training pattern request: 00 none, 01 TPS1, 10 TPS2, 11 TPS3.
REQ-006 SHALL have port phy_instruct_vld  in  1  request valid, one-cycle pulse from the CR/EQ mux.
REQ-007 SHALL have port phy_adj_lc  in  2  lane count code: 00 one lane, 01 two lanes, 11 four lanes, 10 illegal.
REQ-008 SHALL have port phy_adj_bw  in  8  link rate code: legal values are 0x06, 0x0A, 0x14, 0x1E.
REQ-009 SHALL have port phy_tps_o  out  2  applied training pattern.
REQ-010 SHALL have port phy_lc_o  out  2  applied lane count code.
REQ-011 SHALL have port phy_bw_o  out  8  applied link rate code.
REQ-012 SHALL have port phy_cfg_stb  out  1  one-cycle pulse when new values are driven to the PHY.
REQ-013 SHALL have port phy_settled  out  1  one-cycle pulse when the settle period ends.
REQ-014 SHALL have port seq_busy  out  1  high in every state except IDLE.
REQ-015 SHALL have port cfg_err  out  1  sticky flag for an illegal request; cleared only by rst.

Function
REQ-016 SHALL implement a state machine with states IDLE, APPLY, SETTLE, DONE.
REQ-017 SHALL accept a request in IDLE when phy_instruct_vld=1: request sampled at cycle N, state APPLY at N+1.
REQ-018 SHALL, in APPLY, update phy_tps_o, phy_lc_o and phy_bw_o, assert phy_cfg_stb for exactly one cycle, then enter SETTLE.
REQ-019 SHALL load the settle counter with SETTLE_LONG if lc or bw differs from the currently applied values, otherwise with SETTLE_SHORT.
REQ-020 SHALL decrement the counter once per SETTLE cycle and enter DONE after exactly the loaded number of SETTLE cycles; phy_settled therefore pulses at cycle N+2+S.
REQ-021 SHALL return from DONE to IDLE in one cycle, or go straight to APPLY if a request is pending.
REQ-022 SHALL store a request that arrives while seq_busy=1 in a one-entry pending buffer; a newer request overwrites an older one.
REQ-023 SHALL, on entering DONE with a pending request, serve that request in the following APPLY and clear the buffer.
REQ-024 SHALL treat a request with lc=10 or a non-legal bw as illegal: outputs are not updated, phy_cfg_stb is not pulsed, cfg_err is set, and the state stays or returns to IDLE.
REQ-025 SHALL size the settle counter as $clog2(max(SETTLE_LONG,SETTLE_SHORT)+1) bits; SETTLE_SHORT=0 gives a single SETTLE cycle.

Reset
REQ-026 SHALL, while rst=1 on a clock edge: state IDLE; phy_tps_o=00, phy_lc_o=00, phy_bw_o=0x06; phy_cfg_stb, phy_settled, seq_busy and cfg_err all 0; pending buffer and counter cleared.
REQ-027 SHALL abort any operation in progress when rst is asserted, with no phy_settled pulse.

Configuration
REQ-028 SHALL, when macro PHY_CFG_SEQ_STATUS_EN is defined, add output ovr_cnt (8 bits); it counts pending-buffer overwrites, saturates at 0xFF and is reset to 0.
REQ-029 SHALL, when PHY_CFG_SEQ_STATUS_EN is undefined, have no ovr_cnt port and no counter logic, with all other behaviour unchanged.

Structure
REQ-030 SHALL take the state enum, the TPS codes, the lane-count codes and the legal link-rate constants from shared package dp_lt_pkg.
REQ-031 SHALL have no sub-module; rate/lane legality is a package function.

Verification
REQ-032 SHALL cover: after reset, vld with tps=01, lc=11, bw=0x0A -> phy_cfg_stb at N+1, phy_settled at N+102, outputs 01/11/0x0A.
REQ-033 SHALL cover: same lc/bw, tps=10 -> phy_settled at N+6.
REQ-034 SHALL cover: vld with lc=10 -> no phy_cfg_stb, cfg_err=1 until reset.
REQ-035 SHALL cover: two requests during SETTLE (tps=10, then tps=11) -> only tps=11 applied, directly after DONE; ovr_cnt=1 with the macro defined.
REQ-036 SHALL cover: rst asserted mid-SETTLE -> next cycle IDLE, outputs at reset values, no phy_settled.
REQ-037 SHALL cover: vld in the DONE cycle -> buffered and applied in the next cycle, with no extra IDLE cycle.
